// File: rtl/spad_read_sequencer.sv
// spad_read_sequencer: scans all 1024 SPAD pixel addresses during the read phase,
// holding each for CLKS_PER_PIXEL clocks with a read strobe after one setup cycle.
module spad_read_sequencer #(
    parameter int CLKS_PER_PIXEL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ReadData,
    output logic       ReadEnable,
    output logic [2:0] RowSelect,
    output logic [5:0] ColSelect,
    output logic       HighLowRows
);
    localparam int SW = $clog2(CLKS_PER_PIXEL);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CLKS_PER_PIXEL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} stateType;

    stateType state, stateNext;
    logic [9:0] pix, pixNext;
    logic [SW-1:0] slot, slotNext;
    logic readDataQ, reNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pix        <= '0;
            slot       <= '0;
            readDataQ  <= 1'b0;
            ReadEnable <= 1'b0;
        end else begin
            state      <= stateNext;
            pix        <= pixNext;
            slot       <= slotNext;
            readDataQ  <= ReadData;
            ReadEnable <= reNext;
        end
    end

    // pix is held at 0 outside SCAN, so the address outputs are zero there
    always_comb begin
        stateNext = state;
        pixNext   = '0;
        slotNext  = '0;
        reNext    = 1'b0;
        case (state)
            IDLE: stateNext = (ReadData && !readDataQ) ? SCAN : IDLE;
            SCAN: begin
                if (!ReadData) begin
                    stateNext = IDLE;
                end else if (slot == LAST_SLOT) begin
                    stateNext = (pix == 10'd1023) ? DONE : SCAN;
                    pixNext   = (pix == 10'd1023) ? 10'd0 : pix + 10'd1;
                end else begin
                    pixNext  = pix;
                    slotNext = slot + 1'b1;
                    reNext   = 1'b1;
                end
            end
            DONE: stateNext = ReadData ? DONE : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign ColSelect   = pix[5:0];
    assign RowSelect   = pix[8:6];
    assign HighLowRows = pix[9];
endmodule

// File: tb/tb_spad_read_sequencer.sv
// tb_spad_read_sequencer: directed scenario checks of the SPAD readout scan.
module tb_spad_read_sequencer;
    localparam int N = 4;
    localparam int SCAN_CLKS = 1024 * N;
    localparam int FRAME = 4608;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ReadData = 1'b0;
    logic       ReadEnable;
    logic [2:0] RowSelect;
    logic [5:0] ColSelect;
    logic       HighLowRows;

    int errors = 0;
    int checks = 0;
    logic [10:0] obsLog [FRAME];

    spad_read_sequencer #(.CLKS_PER_PIXEL(N)) dut (
        .clk(clk),
        .reset(reset),
        .ReadData(ReadData),
        .ReadEnable(ReadEnable),
        .RowSelect(RowSelect),
        .ColSelect(ColSelect),
        .HighLowRows(HighLowRows)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {ReadEnable, HighLowRows, RowSelect, ColSelect};
    endfunction

    // expected {ReadEnable, address} k clocks after the start edge of a scan
    function automatic logic [10:0] expAt(input int k);
        logic [9:0] p;
        p = 10'(k / N);
        return (k < SCAN_CLKS) ? {(k % N) != 0, p} : 11'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runScan(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            obsLog[k] = obs();
        end
    endtask

    function automatic int countBad(input int n);
        int bad = 0;
        for (int k = 0; k < n; k++)
            if (obsLog[k] !== expAt(k)) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        ReadData = 1'b1;
        tick();
        tick();
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=000", obs());
        end
    endtask

    task automatic test_first_pixel();
        reset = 1'b1;
        ReadData = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL first_setup got=%h want=000", obs());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 11'h400) begin
                errors++;
                $display("FAIL first_strobe%0d got=%h want=400", i, obs());
            end
        end
        tick();
        checks++;
        if (obs() !== 11'h001) begin
            errors++;
            $display("FAIL second_pixel_setup got=%h want=001", obs());
        end
        reset = 1'b1;
        ReadData = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_full_scan();
        int bad, reCnt;
        ReadData = 1'b0;
        tick();
        ReadData = 1'b1;
        runScan(FRAME);
        bad = countBad(FRAME);
        reCnt = 0;
        for (int k = 0; k < FRAME; k++) reCnt += int'(obsLog[k][10]);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_scan_sequence bad_cycles=%0d want=0", bad);
        end
        checks++;
        if (reCnt !== 3072) begin
            errors++;
            $display("FAIL full_scan_strobes got=%0d want=3072", reCnt);
        end
        checks++;
        if (obsLog[2048] !== 11'h200) begin
            errors++;
            $display("FAIL half_start got=%h want=200", obsLog[2048]);
        end
        checks++;
        if (obsLog[255] !== 11'h43f || obsLog[256] !== 11'h040) begin
            errors++;
            $display("FAIL col_wrap got=%h,%h want=43f,040", obsLog[255], obsLog[256]);
        end
        checks++;
        if (obsLog[2047] !== 11'h5ff || obsLog[2048] !== 11'h200) begin
            errors++;
            $display("FAIL row_wrap got=%h,%h want=5ff,200", obsLog[2047], obsLog[2048]);
        end
        checks++;
        if (obsLog[4095] !== 11'h7ff || obsLog[4096] !== 11'h000 || obsLog[FRAME-1] !== 11'h000) begin
            errors++;
            $display("FAIL scan_end got=%h,%h,%h want=7ff,000,000",
                     obsLog[4095], obsLog[4096], obsLog[FRAME-1]);
        end
        ReadData = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int bad;
        ReadData = 1'b0;
        tick();
        ReadData = 1'b1;
        runScan(1000);
        checks++;
        if (obsLog[999] !== 11'h4f9) begin
            errors++;
            $display("FAIL abort_before got=%h want=4f9", obsLog[999]);
        end
        ReadData = 1'b0;
        tick();
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL abort_outputs got=%h want=000", obs());
        end
        ReadData = 1'b1;
        runScan(12);
        bad = countBad(12);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_restart bad_cycles=%0d want=0", bad);
        end
        ReadData = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int bad;
        ReadData = 1'b0;
        tick();
        ReadData = 1'b1;
        runScan(2000);
        reset = 1'b1;
        tick();
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL midscan_reset got=%h want=000", obs());
        end
        reset = 1'b0;
        runScan(8);
        bad = countBad(8);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_restart bad_cycles=%0d want=0", bad);
        end
        ReadData = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int f = 0; f < 2; f++) begin
            ReadData = 1'b1;
            runScan(FRAME);
            bad = countBad(FRAME);
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL frame%0d_sequence bad_cycles=%0d want=0", f, bad);
            end
            ReadData = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                checks++;
                if (obs() !== 11'd0) begin
                    errors++;
                    $display("FAIL frame%0d_gap%0d got=%h want=000", f, i, obs());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_full_scan();
        test_abort();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
